// File: rtl/spi_master_seq.sv
// Host-side sequencer for the SPI master. Host bytes queue in a TX FIFO and go to the master one at a time.
// Each byte the master returns is captured into an RX FIFO that the host reads out.
module spi_master_seq #(
   parameter int DEPTH   = 8,
   parameter int AW      = 3,
   parameter int TIMEOUT = 1023
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          seq_en,
   input  logic          wr_en,
   input  logic [7:0]    wr_data,
   input  logic          rd_en,
   output logic [7:0]    rd_data,
   output logic          tx_full,
   output logic [AW:0]   tx_level,
   output logic          rx_empty,
   output logic [AW:0]   rx_level,
   output logic [7:0]    spi_tx_data,
   output logic          spi_trans_en,
   input  logic          spi_done,
   input  logic [7:0]    spi_rx_data,
   output logic          busy,
   output logic          ovf,
   output logic          tmo,
   input  logic          clr_err
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);
   localparam logic [CW-1:0] TMO_CNT = CW'(TIMEOUT);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_GAP   = 2'd3;

   logic [1:0]    state_reg, state_next;
   logic [7:0]    tx_mem [DEPTH];
   logic [7:0]    rx_mem [DEPTH];
   logic [AW-1:0] tx_wr_ptr_reg, tx_rd_ptr_reg, rx_wr_ptr_reg, rx_rd_ptr_reg;
   logic [AW:0]   tx_level_reg, rx_level_reg;
   logic [CW-1:0] cnt_reg;
   logic          done_q_reg;
   logic [7:0]    spi_tx_data_reg;
   logic          trans_en_reg, ovf_reg, tmo_reg;

   logic done_evt, launch, wait_done, wait_tmo;
   logic tx_push, tx_pop, rx_push, rx_pop;

   assign tx_full      = (tx_level_reg == FULL_LVL);
   assign rx_empty     = (rx_level_reg == '0);
   assign tx_level     = tx_level_reg;
   assign rx_level     = rx_level_reg;
   assign rd_data      = rx_mem[rx_rd_ptr_reg];
   assign spi_tx_data  = spi_tx_data_reg;
   assign spi_trans_en = trans_en_reg;
   assign busy         = (state_reg != S_IDLE);
   assign ovf          = ovf_reg;
   assign tmo          = tmo_reg;

   // A launch needs a free RX slot so the eventual capture can never overflow.
   always_comb begin
      done_evt   = spi_done & ~done_q_reg;
      launch     = (state_reg == S_IDLE) & seq_en & (tx_level_reg != '0) & (rx_level_reg != FULL_LVL);
      wait_done  = (state_reg == S_WAIT) & done_evt;
      wait_tmo   = (state_reg == S_WAIT) & ~done_evt & (cnt_reg == TMO_CNT);
      tx_push    = wr_en & ~tx_full;
      tx_pop     = launch;
      rx_push    = wait_done;
      rx_pop     = rd_en & ~rx_empty;
      state_next = state_reg;
      case (state_reg)
         S_IDLE:  if (launch) state_next = S_START;
         S_START: state_next = S_WAIT;
         S_WAIT:  if (wait_done || wait_tmo) state_next = S_GAP;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wr_ptr_reg] <= wr_data;
      if (rx_push) rx_mem[rx_wr_ptr_reg] <= spi_rx_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg       <= S_IDLE;
         tx_wr_ptr_reg   <= '0;
         tx_rd_ptr_reg   <= '0;
         rx_wr_ptr_reg   <= '0;
         rx_rd_ptr_reg   <= '0;
         tx_level_reg    <= '0;
         rx_level_reg    <= '0;
         cnt_reg         <= '0;
         done_q_reg      <= 1'b0;
         spi_tx_data_reg <= 8'h00;
         trans_en_reg    <= 1'b0;
         ovf_reg         <= 1'b0;
         tmo_reg         <= 1'b0;
      end else begin
         state_reg    <= state_next;
         done_q_reg   <= spi_done;
         trans_en_reg <= launch;

         if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + 1'b1;
         if (tx_pop) begin
            tx_rd_ptr_reg   <= tx_rd_ptr_reg + 1'b1;
            spi_tx_data_reg <= tx_mem[tx_rd_ptr_reg];
         end
         case ({tx_push, tx_pop})
            2'b10:   tx_level_reg <= tx_level_reg + 1'b1;
            2'b01:   tx_level_reg <= tx_level_reg - 1'b1;
            default: tx_level_reg <= tx_level_reg;
         endcase

         if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + 1'b1;
         if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + 1'b1;
         case ({rx_push, rx_pop})
            2'b10:   rx_level_reg <= rx_level_reg + 1'b1;
            2'b01:   rx_level_reg <= rx_level_reg - 1'b1;
            default: rx_level_reg <= rx_level_reg;
         endcase

         if (state_reg == S_START)
            cnt_reg <= '0;
         else if (state_reg == S_WAIT && !wait_done && !wait_tmo)
            cnt_reg <= cnt_reg + CW'(1);

         // Clear wins over a same-cycle set.
         if (clr_err)
            ovf_reg <= 1'b0;
         else if (wr_en && tx_full)
            ovf_reg <= 1'b1;

         if (clr_err)
            tmo_reg <= 1'b0;
         else if (wait_tmo)
            tmo_reg <= 1'b1;
      end
   end

endmodule

// File: tb/tb_spi_master_seq.sv
// Directed bench for spi_master_seq: expected TX bytes and RX bytes are queued as stimulus is issued,
// and monitors pop and compare them on every transfer pulse and every host read.
module tb_spi_master_seq;

   localparam int DEPTH   = 8;
   localparam int AW      = 3;
   localparam int TIMEOUT = 15;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          seq_en = 1'b0;
   logic          wr_en = 1'b0;
   logic [7:0]    wr_data = 8'h00;
   logic          rd_en = 1'b0;
   logic [7:0]    rd_data;
   logic          tx_full;
   logic [AW:0]   tx_level;
   logic          rx_empty;
   logic [AW:0]   rx_level;
   logic [7:0]    spi_tx_data;
   logic          spi_trans_en;
   logic          spi_done;
   logic [7:0]    spi_rx_data;
   logic          busy;
   logic          ovf;
   logic          tmo;
   logic          clr_err = 1'b0;

   // Bench-side master: either the echo model or manual drive from the main sequence.
   logic          master_on = 1'b0;
   logic          m_done = 1'b0;
   logic [7:0]    m_data = 8'h00;
   logic          h_done = 1'b0;
   logic [7:0]    h_data = 8'h00;

   assign spi_done    = master_on ? m_done : h_done;
   assign spi_rx_data = master_on ? m_data : h_data;

   int checks = 0;
   int errors = 0;
   int pulse_cnt = 0;
   logic [7:0] exp_tx[$];
   logic [7:0] exp_rx[$];

   spi_master_seq #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .seq_en(seq_en), .wr_en(wr_en), .wr_data(wr_data),
      .rd_en(rd_en), .rd_data(rd_data), .tx_full(tx_full), .tx_level(tx_level),
      .rx_empty(rx_empty), .rx_level(rx_level), .spi_tx_data(spi_tx_data),
      .spi_trans_en(spi_trans_en), .spi_done(spi_done), .spi_rx_data(spi_rx_data),
      .busy(busy), .ovf(ovf), .tmo(tmo), .clr_err(clr_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic write_byte(input logic [7:0] b);
      wr_en = 1'b1;
      wr_data = b;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic read_n(input int n);
      for (int k = 0; k < n; k++) begin
         int g = 0;
         while (rx_empty && g < 400) begin
            tick();
            g++;
         end
         check("rx_data_available", rx_empty, 1'b0);
         rd_en = 1'b1;
         tick();
         rd_en = 1'b0;
      end
   endtask

   // Echo master: answers each pulse with a done pulse after a few cycles, returning the sent byte.
   always begin
      @(posedge clk);
      #1;
      if (master_on && spi_trans_en) begin
         repeat (3) begin
            @(posedge clk);
            #1;
         end
         m_data = spi_tx_data;
         m_done = 1'b1;
         @(posedge clk);
         #1;
         m_done = 1'b0;
      end
   end

   // TX monitor: every transfer pulse must carry the next expected byte.
   always @(negedge clk) begin
      if (rst && spi_trans_en) begin
         pulse_cnt++;
         $display("tx pulse %0d data=%02h", pulse_cnt, spi_tx_data);
         if (exp_tx.size() == 0) begin
            check("tx_pulse_expected", 32'd0, 32'd1);
         end else begin
            check("tx_data", spi_tx_data, exp_tx.pop_front());
         end
      end
   end

   // RX monitor: every host pop must return the next expected byte.
   always @(negedge clk) begin
      if (rst && rd_en && !rx_empty) begin
         $display("rx read data=%02h level=%0d", rd_data, rx_level);
         if (exp_rx.size() == 0) begin
            check("rx_read_expected", 32'd0, 32'd1);
         end else begin
            check("rx_data", rd_data, exp_rx.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int p0;
      int g;

      // Reset state
      tick(2);
      check("rst_tx_level", tx_level, 0);
      check("rst_rx_level", rx_level, 0);
      check("rst_rx_empty", rx_empty, 1);
      check("rst_tx_full", tx_full, 0);
      check("rst_busy", busy, 0);
      check("rst_trans_en", spi_trans_en, 0);
      check("rst_tx_data", spi_tx_data, 0);
      check("rst_flags", {ovf, tmo}, 0);
      rst = 1'b1;
      seq_en = 1'b1;
      tick();

      // Single byte, manual master answering 6 cycles after the pulse
      exp_tx.push_back(8'hA5);
      exp_rx.push_back(8'h3C);
      write_byte(8'hA5);
      check("t1_no_pulse_e0", spi_trans_en, 0);
      tick();
      check("t1_pulse_e1", spi_trans_en, 1);
      check("t1_tx_data", spi_tx_data, 8'hA5);
      tick();
      check("t1_pulse_width", spi_trans_en, 0);
      check("t1_busy_wait", busy, 1);
      tick(5);
      h_data = 8'h3C;
      h_done = 1'b1;
      tick();
      h_done = 1'b0;
      check("t1_rx_level", rx_level, 1);
      check("t1_rd_data", rd_data, 8'h3C);
      check("t1_busy_gap", busy, 1);
      tick();
      check("t1_busy_idle", busy, 0);
      read_n(1);
      check("t1_rx_empty", rx_empty, 1);

      // Fill TX with seq_en low, overflow, then drain through the echo master
      seq_en = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         exp_tx.push_back(8'(i));
         exp_rx.push_back(8'(i));
         write_byte(8'(i));
      end
      write_byte(8'hFF);
      check("t2_tx_full", tx_full, 1);
      check("t2_tx_level", tx_level, 8);
      check("t2_ovf", ovf, 1);
      master_on = 1'b1;
      p0 = pulse_cnt;
      seq_en = 1'b1;
      read_n(8);
      tick(4);
      check("t2_pulses", pulse_cnt - p0, 8);
      check("t2_tx_level_end", tx_level, 0);
      check("t2_busy_end", busy, 0);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      check("t2_ovf_clr", ovf, 0);

      // RX-full gating with nine queued bytes and no host reads
      seq_en = 1'b0;
      for (int i = 0; i < 9; i++) begin
         exp_tx.push_back(8'h10 + 8'(i));
         exp_rx.push_back(8'h10 + 8'(i));
      end
      for (int i = 0; i < 8; i++) write_byte(8'h10 + 8'(i));
      p0 = pulse_cnt;
      seq_en = 1'b1;
      tick();
      write_byte(8'h18);
      g = 0;
      while (!(rx_level == 8 && !busy) && g < 400) begin
         tick();
         g++;
      end
      tick(10);
      check("t3_rx_level_full", rx_level, 8);
      check("t3_tx_level_held", tx_level, 1);
      check("t3_idle_gated", busy, 0);
      check("t3_pulses_8", pulse_cnt - p0, 8);
      read_n(1);
      g = 0;
      while (!(pulse_cnt - p0 == 9 && rx_level == 8 && !busy) && g < 400) begin
         tick();
         g++;
      end
      check("t3_pulses_9", pulse_cnt - p0, 9);
      check("t3_rx_level_refill", rx_level, 8);
      check("t3_tx_level_empty", tx_level, 0);
      check("t3_no_ovf", ovf, 0);
      read_n(8);

      // Simultaneous push/pop on both FIFOs
      seq_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         exp_tx.push_back(8'h21 + 8'(i));
         exp_rx.push_back(8'h21 + 8'(i));
         write_byte(8'h21 + 8'(i));
      end
      seq_en = 1'b1;
      g = 0;
      while (!(rx_level == 3 && !busy) && g < 400) begin
         tick();
         g++;
      end
      seq_en = 1'b0;
      check("t4_rx_level3", rx_level, 3);
      master_on = 1'b0;
      exp_tx.push_back(8'h24);
      exp_tx.push_back(8'h25);
      exp_tx.push_back(8'h26);
      exp_rx.push_back(8'h24);
      write_byte(8'h24);
      write_byte(8'h25);
      check("t4_tx_level2", tx_level, 2);
      seq_en = 1'b1;
      wr_en = 1'b1;
      wr_data = 8'h26;
      tick();
      wr_en = 1'b0;
      seq_en = 1'b0;
      check("t4_tx_level_same", tx_level, 2);
      check("t4_launch", spi_trans_en, 1);
      tick();
      h_data = 8'h24;
      h_done = 1'b1;
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check("t4_rx_level_same", rx_level, 3);
      tick();
      read_n(3);
      check("t4_rx_empty", rx_empty, 1);

      // Timeout with spi_done held high from the previous transfer
      seq_en = 1'b1;
      tick();
      seq_en = 1'b0;
      check("t5_launch", spi_trans_en, 1);
      tick(16);
      check("t5_tmo_before", tmo, 0);
      check("t5_busy_wait", busy, 1);
      tick();
      check("t5_tmo_set", tmo, 1);
      check("t5_busy_gap", busy, 1);
      tick();
      check("t5_busy_idle", busy, 0);
      check("t5_rx_level", rx_level, 0);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      check("t5_tmo_clr", tmo, 0);
      h_done = 1'b0;

      // Asynchronous reset mid-WAIT
      p0 = pulse_cnt;
      seq_en = 1'b1;
      tick();
      seq_en = 1'b0;
      tick(2);
      check("t6_busy_before", busy, 1);
      #2;
      rst = 1'b0;
      #1;
      check("t6_busy", busy, 0);
      check("t6_trans_en", spi_trans_en, 0);
      check("t6_tx_level", tx_level, 0);
      check("t6_rx_level", rx_level, 0);
      check("t6_rx_empty", rx_empty, 1);
      check("t6_tx_data", spi_tx_data, 0);
      tick();
      rst = 1'b1;
      seq_en = 1'b1;
      tick(8);
      check("t6_no_pulse", pulse_cnt - p0, 1);
      check("t6_tx_empty", tx_level, 0);
      check("t6_rx_empty_after", rx_empty, 1);

      check("exp_tx_drained", exp_tx.size(), 0);
      check("exp_rx_drained", exp_rx.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_master_seq.md
Name: spi_master_seq

Overview:
- Upstream host-side sequencer for the SPI master instance.
- Buffers host bytes in a TX FIFO and presents each byte on the master's parallel data input.
- Pulses the master's transfer enable, waits for the master's completion interrupt, then captures the master's parallel output byte into an RX FIFO for the host.
- Exactly one SPI byte is in flight at a time.

Parameters:
- DEPTH, 8, entries per FIFO (power of two, >=2).
- AW, 3, log2(DEPTH); level outputs are AW+1 bits wide.
- TIMEOUT, 1023, max cycles in WAIT before the transfer is abandoned (>=1).

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  asynchronous, active-low reset.
- seq_en  input  1  1 = sequencer may launch new transfers.
- wr_en  input  1  host push into TX FIFO.
- wr_data  input  8  host byte to transmit.
- rd_en  input  1  host pop from RX FIFO.
- rd_data  output  8  RX FIFO head (first-word fall-through); valid when rx_empty=0.
- tx_full  output  1  TX FIFO full.
- tx_level  output  AW+1  TX FIFO occupancy.
- rx_empty  output  1  RX FIFO empty.
- rx_level  output  AW+1  RX FIFO occupancy.
- spi_tx_data  output  8  byte to master data input; held stable from START until the next pop.
- spi_trans_en  output  1  one-cycle transfer-start pulse to master.
- spi_done  input  1  master completion interrupt (level or pulse).
- spi_rx_data  input  8  master parallel received byte.
- busy  output  1  FSM not in IDLE.
- ovf  output  1  sticky: write attempted while tx_full.
- tmo  output  1  sticky: WAIT timed out.
- clr_err  input  1  clears ovf and tmo.

Behaviour:
- Reset (rst=0, asynchronous): both FIFOs empty (pointers 0), levels 0, rx_empty=1, tx_full=0, spi_tx_data=0, spi_trans_en=0, busy=0, ovf=0, tmo=0, done_q=0, timeout counter 0, state IDLE. Reset mid-transfer aborts; the in-flight byte is lost.
- TX FIFO:
  - wr_en with tx_full=0: write at wr_ptr.
  - wr_en with tx_full=1: byte dropped, ovf<=1.
  - Simultaneous push and FSM pop: tx_level unchanged.
- RX FIFO:
  - rd_en with rx_empty=1 is ignored; no underflow flag.
  - Simultaneous FSM push and host pop: rx_level unchanged.
  - Pointers wrap modulo DEPTH; full/empty come from the AW+1-bit level.
- Done detection: done_evt = spi_done & ~done_q, where done_q is spi_done registered. Only a rising edge counts.
- FSM states: IDLE, START, WAIT, GAP.
  - IDLE: if seq_en=1, tx_level!=0 and rx_level<DEPTH, then pop TX head into spi_tx_data and go to START. Otherwise stay.
  - START: spi_trans_en=1 for exactly this cycle. Counter cleared. Go to WAIT.
  - WAIT: if done_evt, push spi_rx_data into RX FIFO this edge and go to GAP. Else if counter==TIMEOUT, set tmo<=1, push nothing, go to GAP. Else counter+1.
  - GAP: one idle cycle so the master can deassert SS. Then go to IDLE.
- Timeout boundary: done_evt and counter==TIMEOUT in the same cycle: done wins, tmo not set.
- RX space check: the check in IDLE reserves a slot. Only one byte is in flight and the host can only pop, so the RX push never finds a full FIFO.
- seq_en deassert mid-transfer: the current transfer completes normally; no new launch.
- Error flags: clr_err has priority over a same-cycle set, i.e. the flag reads 0 after that edge.
- Outputs:
  - spi_trans_en is registered, high only in START.
  - busy = (state!=IDLE).
- Latency:
  - wr_en at edge E0 gives spi_trans_en high E1–E2 (minimum).
  - done_evt at edge Ek makes the byte visible on rd_data after Ek.
  - The next START is no earlier than Ek+2.
  - Minimum spacing between spi_trans_en pulses is 4 cycles (START, WAIT≥1, GAP, IDLE).

Test Plan:
- Reset, then write 0xA5 at E0; model master asserts spi_done 6 cycles after the pulse with spi_rx_data=0x3C -> spi_trans_en high exactly one cycle after E1, spi_tx_data=0xA5, rd_data=0x3C, rx_level=1, busy returns 0 two edges after done.
- Write 8 bytes 0x01..0x08 back-to-back with seq_en=0, then a 9th write 0xFF -> tx_full=1, tx_level=8, ovf=1, 0xFF never transmitted. Then seq_en=1 with a looping master echo -> 8 pulses, RX reads 0x01..0x08 in order.
- RX full gating: host never reads, 9 bytes queued -> exactly 8 transfers. After rx_level=8 the FSM stays in IDLE with tx_level=1. One rd_en -> the 9th transfer launches.
- TIMEOUT=15, spi_done held 0 -> WAIT lasts 16 cycles, tmo=1, rx_level stays 0. clr_err -> tmo=0. Holding spi_done=1 from a prior transfer does not count as a new done.
- Simultaneous: FSM push and rd_en in the same cycle at rx_level=3 -> rx_level stays 3. wr_en together with an IDLE pop at tx_level=2 -> tx_level stays 2.
- Assert rst=0 asynchronously mid-WAIT (between clock edges) -> all outputs take their reset values immediately. After release no spurious spi_trans_en; FIFOs empty.
